picosoc_mem_loader: RTL and testbench

//  Initiator for the picosoc_mem SRAM port (wen/addr/wdata, rdata one clock after addr).

---
 rtl/picosoc_ldr_pkg.sv | 22 ++
 rtl/picosoc_mem_loader.sv | 156 +++++++++++++++
 tb/tb_picosoc_mem_loader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/picosoc_ldr_pkg.sv
// Shared definitions for the picosoc memory loader: FSM encoding, write-enable
// pattern and memory read latency.
package picosoc_ldr_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WRITE  = 3'd1;
  localparam logic [2:0] ST_READ   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    WRITE  = ST_WRITE,
    READ   = ST_READ,
    DRAIN  = ST_DRAIN,
    FINISH = ST_FINISH
  } ldr_state_e;

  localparam logic [3:0] WEN_ALL = 4'hF;
  localparam int         RD_LAT  = 2;

endpackage

// File: rtl/picosoc_mem_loader.sv
// Streams host words into a picosoc_mem window, optionally reads the window
// back and compares a wrapping 32-bit sum against what was written.
module picosoc_mem_loader
  import picosoc_ldr_pkg::*;
#(
  parameter int WORDS  = 256,
  parameter int ADDR_W = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic              cfg_verify,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       checksum
);

  localparam logic [ADDR_W:0]   WORDS_EXT = (ADDR_W+1)'(WORDS);
  localparam logic [ADDR_W-1:0] ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ZERO      = {ADDR_W{1'b0}};

  ldr_state_e        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_verify;
  logic [RD_LAT-1:0] r_vpipe;
  logic [31:0]       r_rdsum;

  logic [ADDR_W:0]   w_end;
  logic              w_oob;
  logic              w_last;
  logic              w_hs;
  logic [31:0]       w_rdsum_next;

  // Bounds check is one bit wider than the address so base+len cannot wrap.
  assign w_end  = {1'b0, cfg_base} + {1'b0, cfg_len};
  assign w_oob  = (w_end > WORDS_EXT);
  assign w_last = ((r_cnt + ONE) == r_len);
  assign w_hs   = s_valid & s_ready;

  // Read data for the word at the head of the valid pipe joins the readback sum.
  always_comb begin
    w_rdsum_next = r_rdsum;
    if (r_vpipe[RD_LAT-1]) begin
      w_rdsum_next = r_rdsum + mem_rdata;
    end else begin
      w_rdsum_next = r_rdsum;
    end
  end

  // Loader FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_base    <= ZERO;
      r_len     <= ZERO;
      r_cnt     <= ZERO;
      r_verify  <= 1'b0;
      r_vpipe   <= {RD_LAT{1'b0}};
      r_rdsum   <= 32'h0;
      s_ready   <= 1'b0;
      mem_wen   <= 4'h0;
      mem_addr  <= ZERO;
      mem_wdata <= 32'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      checksum  <= 32'h0;
    end else begin
      mem_wen <= 4'h0;
      done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cfg_start) begin
            r_base   <= cfg_base;
            r_len    <= cfg_len;
            r_verify <= cfg_verify;
            r_cnt    <= ZERO;
            r_vpipe  <= {RD_LAT{1'b0}};
            r_rdsum  <= 32'h0;
            err      <= 1'b0;
            checksum <= 32'h0;
            busy     <= 1'b1;
            if (cfg_len == ZERO) begin
              r_state <= FINISH;
            end else if (w_oob) begin
              err     <= 1'b1;
              r_state <= FINISH;
            end else begin
              s_ready <= 1'b1;
              r_state <= WRITE;
            end
          end
        end
        WRITE: begin
          if (w_hs) begin
            mem_wen   <= WEN_ALL;
            mem_addr  <= r_base + r_cnt;
            mem_wdata <= s_data;
            checksum  <= checksum + s_data;
            if (w_last) begin
              s_ready <= 1'b0;
              r_cnt   <= ZERO;
              r_state <= r_verify ? READ : FINISH;
            end else begin
              r_cnt <= r_cnt + ONE;
            end
          end
        end
        READ: begin
          mem_addr <= r_base + r_cnt;
          r_vpipe  <= {r_vpipe[RD_LAT-2:0], 1'b1};
          r_rdsum  <= w_rdsum_next;
          if (w_last) begin
            r_state <= DRAIN;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        DRAIN: begin
          r_vpipe <= {r_vpipe[RD_LAT-2:0], 1'b0};
          r_rdsum <= w_rdsum_next;
          // Leave once the word consumed on this edge is the last one in flight.
          if (r_vpipe[RD_LAT-2:0] == {(RD_LAT-1){1'b0}}) begin
            r_state <= FINISH;
            if (w_rdsum_next != checksum) begin
              err <= 1'b1;
            end
          end
        end
        FINISH: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          s_ready <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_picosoc_mem_loader.sv
// Randomised scoreboard bench for picosoc_mem_loader with a registered-read
// memory model that can corrupt one address on readback.
module tb_picosoc_mem_loader;

  localparam int AW    = 22;
  localparam int WORDS = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [AW-1:0] cfg_len = '0;
  logic          cfg_verify = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   s_data = 32'h0;
  logic [3:0]    mem_wen;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;
  logic          busy;
  logic          done;
  logic          err;
  logic [31:0]   checksum;

  always #5 clk = ~clk;

  picosoc_mem_loader #(.WORDS(WORDS), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base(cfg_base),
    .cfg_len(cfg_len), .cfg_verify(cfg_verify), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .err(err), .checksum(checksum)
  );

  // Memory model: registered read, optional +1 corruption on word 2.
  logic [31:0] mem [0:WORDS-1];
  logic        corrupt = 1'b0;
  always @(posedge clk) begin
    if (mem_wen == 4'hF) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:0]] + ((corrupt && mem_addr == 22'd2) ? 32'd1 : 32'd0);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic err; logic [31:0] sum; } res_t;
  wr_t  wr_q[$];
  res_t res_q[$];

  // Write monitor: every write the DUT issues must match the next expected one.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk); #1;
      if (mem_wen != 4'h0) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr=%0h wen=%0h, required no write", mem_addr, mem_wen);
        end else begin
          e = wr_q.pop_front();
          chk("wr_wen", 64'(mem_wen), 64'h0F);
          chk("wr_addr", 64'(mem_addr), 64'(e.addr));
          chk("wr_data", 64'(mem_wdata), 64'(e.data));
        end
      end
    end
  end

  // Completion monitor: each done pulse is matched against the predicted result.
  initial begin
    res_t r;
    logic done_prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (done) begin
        if (done_prev) begin
          checks++; errors++;
          $display("FAIL done_width: done high two cycles, required one");
        end else if (res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: done=1, required no done");
        end else begin
          r = res_q.pop_front();
          chk("done_err", 64'(err), 64'(r.err));
          chk("done_checksum", 64'(checksum), 64'(r.sum));
          chk("done_busy", 64'(busy), 64'h0);
        end
      end
      done_prev = done;
    end
  end

  // vmode: 0 always valid, 1 toggling 1,0,1..., 2 random. dmode: 0 random, 1 counting from 1.
  task automatic run_job(input int base, input int len, input bit verify,
                         input int vmode, input int dmode, input bit inject,
                         input bit abort_rd, input bit chk_b2b);
    logic [31:0] dq[$];
    logic [31:0] sum = 32'h0;
    bit   inb, stream, v, pend_srdy = 0, busy_bad = 0, seen_done = 0;
    int   acc = 0, cyc = 0, last_cyc = -1;
    res_t r;
    inb    = (len != 0) && (base + len <= WORDS);
    stream = inb;
    for (int i = 0; i < len; i++) begin
      dq.push_back(dmode == 1 ? 32'(i + 1) : $urandom);
      sum += dq[i];
    end
    r.err = (len != 0) && (!inb || (verify && corrupt && base <= 2 && 2 < base + len));
    r.sum = inb ? sum : 32'h0;
    res_q.push_back(r);
    @(negedge clk);
    cfg_start = 1'b1; cfg_base = AW'(base); cfg_len = AW'(len); cfg_verify = verify;
    while (!seen_done) begin
      @(negedge clk);
      cyc++;
      cfg_start = 1'b0;
      if (done) begin
        seen_done = 1;
        break;
      end
      if (!busy) busy_bad = 1;
      if (pend_srdy) begin
        chk("s_ready_drop", 64'(s_ready), 64'h0);
        pend_srdy = 0;
      end
      if (inject && cyc == 3) begin
        cfg_start = 1'b1; cfg_base = AW'(100); cfg_len = AW'(5); cfg_verify = 1'b0;
      end
      if (stream && acc < len) begin
        v = (vmode == 0) ? 1'b1 : (vmode == 1) ? bit'(cyc % 2) : bit'($urandom_range(0, 1));
        s_valid = v;
        s_data  = v ? dq[acc] : $urandom;
        if (v && s_ready) begin
          wr_q.push_back('{addr: AW'(base + acc), data: dq[acc]});
          acc++;
          if (acc == len) begin
            last_cyc  = cyc;
            pend_srdy = 1;
          end
        end
      end else begin
        s_valid = !inb;
        s_data  = $urandom;
      end
      if (abort_rd && last_cyc > 0 && cyc == last_cyc + 4) begin
        rst = 1'b1;
        res_q.delete();
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_done", 64'(done), 64'h0);
        chk("abort_wen_addr", {mem_wen, 38'(mem_addr)}, 64'h0);
        chk("abort_sready_err", {s_ready, err}, 64'h0);
        chk("abort_checksum", 64'(checksum), 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        s_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_no_done_busy", {done, busy}, 64'h0);
        return;
      end
      if (cyc > 5000) begin
        checks++; errors++;
        $display("FAIL job_timeout: no done after %0d cycles, required done", cyc);
        break;
      end
    end
    s_valid = 1'b0;
    chk("busy_during_job", 64'(busy_bad), 64'h0);
    chk("words_accepted", 64'(acc), 64'(inb ? len : 0));
    if (len == 0) chk("len0_done_latency", 64'(cyc), 64'd2);
    if (chk_b2b) chk("b2b_cycles", 64'(last_cyc), 64'(len));
    repeat (6) @(negedge clk);
    chk("wr_q_drained", 64'(wr_q.size()), 64'h0);
    chk("res_q_drained", 64'(res_q.size()), 64'h0);
    chk("idle_after_job", {busy, s_ready}, 64'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_outputs", {s_ready, mem_wen, done, busy, err}, 64'h0);
    chk("rst_addr_data", {10'h0, mem_addr, mem_wdata}, 64'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", {s_ready, mem_wen, done, busy, err, checksum}, 64'h0);

    run_job(0, 4, 1, 0, 1, 0, 0, 1);     // back-to-back 1,2,3,4 with verify
    run_job(8, 3, 0, 1, 0, 0, 0, 0);     // toggling valid
    run_job(20, 0, 1, 0, 0, 0, 0, 0);    // empty job
    run_job(250, 7, 1, 0, 0, 0, 0, 0);   // out of bounds
    run_job(249, 7, 1, 2, 0, 0, 0, 0);   // ends exactly at the top word
    corrupt = 1'b1;
    run_job(0, 8, 1, 2, 0, 0, 0, 0);     // readback mismatch
    run_job(3, 8, 1, 0, 0, 0, 0, 0);     // corruption outside window
    corrupt = 1'b0;
    run_job(40, 8, 0, 0, 0, 1, 0, 0);    // start ignored mid-write
    run_job(16, 8, 1, 0, 0, 0, 1, 0);    // reset mid-read
    run_job(0, 256, 1, 2, 0, 0, 0, 0);   // full-depth fill
    for (int j = 0; j < 6; j++) begin
      run_job($urandom_range(0, 255), $urandom_range(0, 40), bit'($urandom_range(0, 1)),
              2, 0, 0, 0, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
